// File: rtl/t64_intctl.sv
// t64_intctl: memory-mapped edge-triggered interrupt controller driving the CPU intr/intack handshake
//   clk     in  1     system clock
//   reset   in  1     asynchronous active-low reset
//   ain     in  64    CPU byte address; window at BASE, register select ain[5:3]
//   din     in  64    CPU write data, low NSRC bits used
//   width   in  2     CPU access width, no effect on registers
//   write   in  1     CPU write strobe
//   dout    out 64    combinational read data
//   irq     in  NSRC  rising-edge interrupt sources
//   intack  in  1     CPU interrupt acknowledge
//   intr    out 1     interrupt request, high exactly in REQ
module t64_intctl #(
    parameter int          NSRC = 8,
    parameter logic [63:0] BASE = 64'hFFFF_FF00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [63:0]     ain,
    input  logic [63:0]     din,
    input  logic [1:0]      width,
    input  logic            write,
    output logic [63:0]     dout,
    input  logic [NSRC-1:0] irq,
    input  logic            intack,
    output logic            intr
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
    state_t          r_state, w_next;
    logic [NSRC-1:0] r_irq_q, r_pend, r_mask;
    logic [2:0]      r_vec, w_idx;
    logic            r_vvalid, r_intr;
    logic            w_hit, w_wr, w_eoi, w_ack, w_any;
    logic [2:0]      w_sel;
    logic [NSRC-1:0] w_set, w_clr, w_ack_clr, w_cand;
    logic [63:0]     w_rd;
    logic            w_unused;
    assign w_unused  = ^{width, din[63:NSRC], ain[2:0]};
    assign w_hit     = ain[63:6] == BASE[63:6];
    assign w_sel     = ain[5:3];
    assign w_wr      = write && w_hit;
    assign w_eoi     = w_wr && w_sel == 3'd3 && r_state == SERVICE;
    assign w_ack     = r_state == REQ && intack;
    assign w_set     = irq & ~r_irq_q;
    assign w_clr     = (w_wr && w_sel == 3'd2) ? din[NSRC-1:0] : '0;
    assign w_ack_clr = w_ack ? NSRC'(1'b1) << r_vec : '0;
    assign w_cand    = r_pend & r_mask;
    assign w_any     = |w_cand;
    assign intr      = r_intr;
    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        w_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_cand[i]) w_idx = 3'(i);
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_any) ? REQ :
                 w_ack                      ? SERVICE :
                 w_eoi                      ? IDLE : r_state;
    end
    assign w_rd = w_sel == 3'd0 ? 64'(r_pend) :
                  w_sel == 3'd1 ? 64'(r_mask) :
                  w_sel == 3'd4 ? {r_vvalid, 60'd0, r_vec} :
                  w_sel == 3'd5 ? {62'd0, r_state} : 64'd0;
    assign dout = (w_hit && !write) ? w_rd : 64'd0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_q  <= '0;
            r_pend   <= '0;
            r_mask   <= '0;
            r_vec    <= '0;
            r_vvalid <= 1'b0;
            r_state  <= IDLE;
            r_intr   <= 1'b0;
        end else begin
            r_irq_q <= irq;
            // A new edge wins over any same-cycle clear of that bit.
            r_pend  <= w_set | (r_pend & ~w_clr & ~w_ack_clr);
            if (w_wr && w_sel == 3'd1) r_mask <= din[NSRC-1:0];
            if (r_state == IDLE && w_any) r_vec <= w_idx;
            if (w_ack) r_vvalid <= 1'b1;
            else if (w_eoi) r_vvalid <= 1'b0;
            r_state <= w_next;
            r_intr  <= w_next == REQ;
        end
    end
endmodule

// File: tb/tb_t64_intctl.sv
// tb_t64_intctl: scoreboard bench for t64_intctl with directed vectors
module tb_t64_intctl;
    localparam logic [63:0] BASE = 64'hFFFF_FF00;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] ain = '0, din = '0;
    logic [1:0]  width = 2'd3;
    logic        write = 1'b0, intack = 1'b0, chk = 1'b0;
    logic [7:0]  irq = '0;
    logic [63:0] dout;
    logic        intr;
    int          total = 0, bad = 0;
    string       nq[$];
    logic [64:0] eq[$];

    t64_intctl #(.NSRC(8), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .ain(ain), .din(din), .width(width), .write(write),
        .dout(dout), .irq(irq), .intack(intack), .intr(intr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk) begin
            logic [64:0] e;
            logic [63:0] a;
            string       n;
            total++;
            if (eq.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty actual=none required=entry");
            end else begin
                e = eq.pop_front();
                n = nq.pop_front();
                a = e[64] ? {63'd0, intr} : dout;
                if (a !== e[63:0]) begin
                    bad++;
                    $display("FAIL %s actual=%h required=%h", n, a, e[63:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [63:0] d);
        ain = BASE + 64'(sel) * 64'd8;
        din = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic pk(input string n, input logic is_i, input logic [63:0] a, input logic [63:0] e);
        ain = a;
        nq.push_back(n);
        eq.push_back({is_i, e});
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic rd(input string n, input int sel, input logic [63:0] e);
        pk(n, 1'b0, BASE + 64'(sel) * 64'd8, e);
    endtask

    task automatic pi(input string n, input logic e);
        pk(n, 1'b1, ain, {63'd0, e});
    endtask

    task automatic ack;
        intack = 1'b1;
        tick();
        intack = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b1;
        tick();
        wr(1, 64'h01);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        pi("rst_pre_intr", 1'b1);
        tick();
        reset = 1'b0;
        pi("rst_async_intr", 1'b0);
        reset = 1'b1;
        rd("rst_pending", 0, 64'd0);
        rd("rst_mask", 1, 64'd0);
        rd("rst_vector", 4, 64'd0);
        rd("rst_status", 5, 64'd0);

        wr(1, 64'h01);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        pi("single_lat1", 1'b0);
        tick();
        pi("single_lat2", 1'b1);
        rd("single_status_req", 5, 64'd1);
        ack();
        pi("single_ack_intr", 1'b0);
        rd("single_vector", 4, 64'h8000_0000_0000_0000);
        rd("single_pending", 0, 64'd0);
        rd("single_status_svc", 5, 64'd2);
        wr(3, 64'd0);
        rd("single_eoi_status", 5, 64'd0);
        rd("single_eoi_vector", 4, 64'd0);

        wr(1, 64'hFF);
        irq = 8'h24;
        tick();
        irq = 8'h00;
        tick();
        tick();
        rd("prio_status", 5, 64'd1);
        ack();
        rd("prio_vec1", 4, 64'h8000_0000_0000_0002);
        rd("prio_pending", 0, 64'h20);
        wr(3, 64'd0);
        pi("prio_gap", 1'b0);
        tick();
        pi("prio_b2b_intr", 1'b1);
        ack();
        rd("prio_vec2", 4, 64'h8000_0000_0000_0005);
        wr(3, 64'd0);
        rd("prio_done_status", 5, 64'd0);

        wr(1, 64'h00);
        irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        rd("mask_pending", 0, 64'h08);
        pi("mask_no_intr", 1'b0);
        wr(1, 64'h08);
        pi("mask_unmask_lat0", 1'b0);
        tick();
        pi("mask_unmask_lat1", 1'b1);
        wr(3, 64'd0);
        pi("eoi_in_req_intr", 1'b1);
        rd("eoi_in_req_status", 5, 64'd1);
        ack();
        wr(3, 64'd0);
        rd("mask_done_status", 5, 64'd0);
        rd("mask_done_pending", 0, 64'd0);

        wr(1, 64'h00);
        irq = 8'h02;
        wr(2, 64'h02);
        rd("set_beats_clear", 0, 64'h02);
        wr(2, 64'h02);
        rd("clear_works", 0, 64'd0);
        tick();
        tick();
        rd("held_level_once", 0, 64'd0);
        irq = 8'h00;

        irq = 8'h10;
        tick();
        irq = 8'h00;
        intack = 1'b1;
        tick();
        tick();
        rd("idle_intack_pending", 0, 64'h10);
        rd("idle_intack_status", 5, 64'd0);
        intack = 1'b0;
        rd("clear_reads_zero", 2, 64'd0);

        wr(7, 64'hFF);
        rd("unmapped_read", 7, 64'd0);
        wr(1, 64'h0F);
        pk("nohit_read", 1'b0, 64'hFFFF_FE08, 64'd0);
        rd("mask_read", 1, 64'h0F);
        din = 64'h0F;
        write = 1'b1;
        rd("read_during_write", 1, 64'd0);
        write = 1'b0;
        rd("mask_after_write", 1, 64'h0F);

        tick();
        if (eq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", eq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
